score_sequencer: RTL and testbench

Parametrised frame sequencer that replaces the hand-written IDLE/PROC/NORM/SEND control in the recogniser top level. Per received feature vector it:
- starts the GDP controller;
- buffers every senone score and tracks the best one;
- optionally normalises all scores against the best;
- streams results to the data UART one number at a time.

Sits between uart, gdp_controller and the status LED logic; subsumes the separate max unit.

---
 rtl/score_sequencer_if.sv | 38 +++
 rtl/score_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_score_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_sequencer_if.sv
// Handshake bundle between the frame sequencer and the UART / GDP controller /
// status logic. The slave modport is the sequencer's view.
interface score_sequencer_if #(
  parameter int SCORE_W = 16,
  parameter int IDX_W   = 8
);
  logic                      rx_available;
  logic                      send_all;
  logic                      gdp_idle;
  logic                      start_gdp;
  logic                      score_ready;
  logic [IDX_W-1:0]          senone_idx;
  logic signed [SCORE_W-1:0] senone_score;
  logic                      last_senone;
  logic                      tx_ready;
  logic                      start_tx;
  logic signed [SCORE_W-1:0] tx_num;
  logic [IDX_W-1:0]          tx_idx;
  logic signed [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]          best_idx;
  logic [1:0]                state;
  logic                      frame_done;
  logic                      overrun;

  modport slave (
    input  rx_available, send_all, gdp_idle, score_ready, senone_idx,
           senone_score, last_senone, tx_ready,
    output start_gdp, start_tx, tx_num, tx_idx, best_score, best_idx,
           state, frame_done, overrun
  );

  modport master (
    output rx_available, send_all, gdp_idle, score_ready, senone_idx,
           senone_score, last_senone, tx_ready,
    input  start_gdp, start_tx, tx_num, tx_idx, best_score, best_idx,
           state, frame_done, overrun
  );
endinterface

// File: rtl/score_sequencer.sv
// Per-frame sequencer: starts GDP, buffers and tracks the best senone score,
// optionally normalises against the best, and streams results to the UART.
module score_sequencer #(
  parameter int N_SENONES = 10,
  parameter int SCORE_W   = 16,
  parameter int IDX_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  score_sequencer_if.slave  bus
);

  localparam int CW = IDX_W + 1;
  localparam int AW = (N_SENONES > 1) ? $clog2(N_SENONES) : 1;
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] SCORE_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic [CW-1:0] N_CNT = CW'(N_SENONES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_NORM = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      send_all_q, send_all_d;
  logic [CW-1:0]             count_q, count_d;
  logic [CW-1:0]             ptr_q, ptr_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic                      start_gdp_q, start_gdp_d;
  logic                      start_tx_q, start_tx_d;
  logic                      frame_done_q, frame_done_d;
  logic signed [SCORE_W-1:0] tx_num_q, tx_num_d;
  logic [IDX_W-1:0]          tx_idx_q, tx_idx_d;
  logic                      overrun_q, overrun_d;

  logic signed [SCORE_W-1:0] score_mem [N_SENONES];
  logic                      buf_we;
  logic [AW-1:0]             buf_addr;
  logic signed [SCORE_W-1:0] buf_wdata;
  logic signed [SCORE_W-1:0] rd_data;
  logic signed [SCORE_W:0]   diff;
  logic signed [SCORE_W-1:0] diff_sat;
  logic [CW-1:0]             n_words;

  // The incoming index is informational only; storage follows the internal count.
  logic unused_idx;
  assign unused_idx = ^bus.senone_idx;

  assign rd_data = score_mem[ptr_q[AW-1:0]];
  assign n_words = send_all_q ? count_q : CW'(1);

  always_comb begin
    diff = {rd_data[SCORE_W-1], rd_data} - {best_q[SCORE_W-1], best_q};
    if (diff[SCORE_W] != diff[SCORE_W-1]) begin
      diff_sat = diff[SCORE_W] ? SCORE_MIN : SCORE_MAX;
    end else begin
      diff_sat = diff[SCORE_W-1:0];
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d      = state_q;
    send_all_d   = send_all_q;
    count_d      = count_q;
    ptr_d        = ptr_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    start_gdp_d  = 1'b0;
    start_tx_d   = 1'b0;
    frame_done_d = 1'b0;
    tx_num_d     = tx_num_q;
    tx_idx_d     = tx_idx_q;
    buf_we       = 1'b0;
    buf_addr     = count_q[AW-1:0];
    buf_wdata    = bus.senone_score;
    overrun_d    = overrun_q
                 | (bus.rx_available && !(state_q == ST_IDLE && bus.gdp_idle))
                 | (bus.score_ready && state_q != ST_PROC);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.rx_available && bus.gdp_idle) begin
          send_all_d  = bus.send_all;
          count_d     = '0;
          ptr_d       = '0;
          best_d      = SCORE_MIN;
          best_idx_d  = '0;
          start_gdp_d = 1'b1;
          state_d     = ST_PROC;
        end
      end
      ST_PROC: begin
        if (bus.score_ready) begin
          buf_we  = 1'b1;
          count_d = count_q + CW'(1);
          // Strict compare keeps the lower index on ties.
          if (bus.senone_score > best_q) begin
            best_d     = bus.senone_score;
            best_idx_d = count_q[IDX_W-1:0];
          end
          if (bus.last_senone || (count_q + CW'(1)) == N_CNT) begin
            ptr_d   = '0;
            state_d = send_all_q ? ST_NORM : ST_SEND;
          end
        end
      end
      ST_NORM: begin
        buf_we    = 1'b1;
        buf_addr  = ptr_q[AW-1:0];
        buf_wdata = diff_sat;
        ptr_d     = ptr_q + CW'(1);
        if ((ptr_q + CW'(1)) == count_q) begin
          ptr_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // A pulse just issued for the last word closes the frame on this cycle.
        if (start_tx_q && ptr_q == n_words) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (bus.tx_ready && !start_tx_q && ptr_q < n_words) begin
          start_tx_d = 1'b1;
          tx_num_d   = send_all_q ? rd_data : best_q;
          tx_idx_d   = send_all_q ? ptr_q[IDX_W-1:0] : best_idx_q;
          ptr_d      = ptr_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      send_all_q   <= 1'b0;
      count_q      <= '0;
      ptr_q        <= '0;
      best_q       <= SCORE_MIN;
      best_idx_q   <= '0;
      start_gdp_q  <= 1'b0;
      start_tx_q   <= 1'b0;
      frame_done_q <= 1'b0;
      tx_num_q     <= '0;
      tx_idx_q     <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      send_all_q   <= send_all_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      start_gdp_q  <= start_gdp_d;
      start_tx_q   <= start_tx_d;
      frame_done_q <= frame_done_d;
      tx_num_q     <= tx_num_d;
      tx_idx_q     <= tx_idx_d;
      overrun_q    <= overrun_d;
    end
  end

  // NOTE: the score buffer is deliberately left unreset; entries are always
  // written in PROC before NORM or SEND reads them.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      score_mem[buf_addr] <= buf_wdata;
    end
  end

  assign bus.state      = state_q;
  assign bus.start_gdp  = start_gdp_q;
  assign bus.start_tx   = start_tx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.tx_num     = tx_num_q;
  assign bus.tx_idx     = tx_idx_q;
  assign bus.best_score = best_q;
  assign bus.best_idx   = best_idx_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: best-only, normalised, saturation,
// tx back-pressure, overrun and mid-frame reset scenarios.
module tb_score_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  score_sequencer_if #(.SCORE_W(16), .IDX_W(8)) bus ();

  score_sequencer #(.N_SENONES(10), .SCORE_W(16), .IDX_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                 pulses;
  logic               seen;
  logic signed [31:0] got_num [16];
  logic [31:0]        got_idx [16];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic mode);
    bus.send_all     = mode;
    bus.gdp_idle     = 1'b1;
    bus.rx_available = 1'b1;
    step();
    bus.rx_available = 1'b0;
    check("accept_state", bus.state, 1);
    check("start_gdp_pulse", bus.start_gdp, 1);
  endtask

  task automatic send_score(input logic signed [15:0] s, input logic [7:0] idx,
                            input logic last);
    bus.score_ready  = 1'b1;
    bus.senone_score = s;
    bus.senone_idx   = idx;
    bus.last_senone  = last;
    step();
    bus.score_ready  = 1'b0;
    bus.last_senone  = 1'b0;
  endtask

  // UART model: raises tx_ready, drops it after each start_tx for 'gap' cycles.
  task automatic run_send(input int gap);
    int   low;
    logic done;
    low    = 0;
    done   = 1'b0;
    pulses = 0;
    bus.tx_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      step();
      if (bus.start_tx === 1'b1) begin
        if (pulses < 16) begin
          got_num[pulses] = bus.tx_num;
          got_idx[pulses] = bus.tx_idx;
        end
        pulses++;
        bus.tx_ready = 1'b0;
        low = gap;
      end else if (low > 0) begin
        low--;
        if (low == 0) bus.tx_ready = 1'b1;
      end
      if (bus.frame_done === 1'b1) done = 1'b1;
    end
    bus.tx_ready = 1'b0;
    check("frame_done_seen", done, 1);
    check("state_after_frame", bus.state, 0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset            = 1'b1;
    bus.rx_available = 1'b0;
    bus.send_all     = 1'b0;
    bus.gdp_idle     = 1'b1;
    bus.score_ready  = 1'b0;
    bus.senone_idx   = '0;
    bus.senone_score = '0;
    bus.last_senone  = 1'b0;
    bus.tx_ready     = 1'b0;
    step(2);
    reset = 1'b0;

    // Reset state
    check("rst_state", bus.state, 0);
    check("rst_start_gdp", bus.start_gdp, 0);
    check("rst_start_tx", bus.start_tx, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_tx_num", bus.tx_num, 0);
    check("rst_tx_idx", bus.tx_idx, 0);
    check("rst_best", bus.best_score, -32768);
    check("rst_best_idx", bus.best_idx, 0);
    check("rst_overrun", bus.overrun, 0);

    // Best-only frame, tie at index 4 must keep index 2
    start_frame(1'b0);
    step();
    check("start_gdp_one_cycle", bus.start_gdp, 0);
    send_score(16'sd5, 8'd0, 1'b0);
    send_score(-16'sd3, 8'd1, 1'b0);
    send_score(16'sd120, 8'd2, 1'b0);
    send_score(16'sd7, 8'd3, 1'b0);
    send_score(16'sd120, 8'd4, 1'b0);
    send_score(16'sd0, 8'd5, 1'b0);
    send_score(-16'sd9, 8'd6, 1'b0);
    send_score(16'sd1, 8'd7, 1'b0);
    send_score(16'sd2, 8'd8, 1'b0);
    send_score(16'sd3, 8'd9, 1'b1);
    check("t1_state_send", bus.state, 3);
    check("t1_best", bus.best_score, 120);
    check("t1_best_idx", bus.best_idx, 2);
    run_send(2);
    check("t1_pulses", pulses, 1);
    check("t1_tx_num", got_num[0], 120);
    check("t1_tx_idx", got_idx[0], 2);
    step(3);
    check("t1_best_hold", bus.best_score, 120);
    check("t1_best_idx_hold", bus.best_idx, 2);
    check("t1_overrun", bus.overrun, 0);

    // Normalised frame with early last_senone: three NORM cycles
    start_frame(1'b1);
    send_score(16'sd100, 8'd0, 1'b0);
    send_score(-16'sd50, 8'd1, 1'b0);
    send_score(16'sd300, 8'd2, 1'b1);
    check("t2_norm_c1", bus.state, 2);
    step();
    check("t2_norm_c2", bus.state, 2);
    step();
    check("t2_norm_c3", bus.state, 2);
    step();
    check("t2_send", bus.state, 3);
    run_send(2);
    check("t2_pulses", pulses, 3);
    check("t2_num0", got_num[0], -200);
    check("t2_idx0", got_idx[0], 0);
    check("t2_num1", got_num[1], -350);
    check("t2_idx1", got_idx[1], 1);
    check("t2_num2", got_num[2], 0);
    check("t2_idx2", got_idx[2], 2);

    // Saturation of -32768 - 32767
    start_frame(1'b1);
    send_score(16'sd32767, 8'd0, 1'b0);
    send_score(-16'sd32768, 8'd1, 1'b1);
    step(2);
    check("t3_send", bus.state, 3);
    run_send(1);
    check("t3_pulses", pulses, 2);
    check("t3_num0", got_num[0], 0);
    check("t3_num1", got_num[1], -32768);
    check("t3_idx1", got_idx[1], 1);

    // tx_ready held low for 20 cycles in SEND
    start_frame(1'b0);
    send_score(16'sd7, 8'd0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.start_tx === 1'b1) pulses++;
    end
    check("t4_no_tx_while_low", pulses, 0);
    check("t4_state_send", bus.state, 3);
    run_send(3);
    check("t4_pulses", pulses, 1);
    check("t4_num", got_num[0], 7);
    check("t4_idx", got_idx[0], 0);

    // rx_available coincides with the final score
    start_frame(1'b0);
    send_score(16'sd4, 8'd0, 1'b0);
    bus.rx_available = 1'b1;
    send_score(16'sd9, 8'd1, 1'b1);
    bus.rx_available = 1'b0;
    check("t5_overrun", bus.overrun, 1);
    check("t5_state", bus.state, 3);
    check("t5_best", bus.best_score, 9);
    check("t5_best_idx", bus.best_idx, 1);
    run_send(1);
    check("t5_pulses", pulses, 1);
    check("t5_num", got_num[0], 9);
    check("t5_idx", got_idx[0], 1);
    check("t5_overrun_sticky", bus.overrun, 1);

    // Full 10-score frame without last_senone, reset after the first word
    start_frame(1'b1);
    for (int i = 0; i < 10; i++) begin
      send_score(16'(i * 10), 8'(i), 1'b0);
    end
    check("t6_count_exit_norm", bus.state, 2);
    step(10);
    check("t6_send", bus.state, 3);
    bus.tx_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (bus.start_tx === 1'b1) seen = 1'b1;
    end
    check("t6_first_tx_seen", seen, 1);
    check("t6_num0", bus.tx_num, -90);
    check("t6_idx0", bus.tx_idx, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_state", bus.state, 0);
    check("t6_rst_start_tx", bus.start_tx, 0);
    check("t6_rst_best", bus.best_score, -32768);
    check("t6_rst_overrun", bus.overrun, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.start_tx === 1'b1) pulses++;
    end
    bus.tx_ready = 1'b0;
    check("t6_no_tx_after_rst", pulses, 0);

    // score_ready in IDLE, rx_available while GDP busy, then a clean frame
    send_score(16'sd50, 8'd0, 1'b0);
    check("t7_idle_score_overrun", bus.overrun, 1);
    check("t7_idle_best_untouched", bus.best_score, -32768);
    bus.gdp_idle     = 1'b0;
    bus.rx_available = 1'b1;
    step();
    bus.rx_available = 1'b0;
    check("t7_busy_rx_ignored", bus.state, 0);
    step();
    check("t7_busy_no_gdp", bus.start_gdp, 0);
    start_frame(1'b0);
    send_score(-16'sd5, 8'd0, 1'b0);
    send_score(-16'sd2, 8'd1, 1'b1);
    check("t7_best", bus.best_score, -2);
    run_send(1);
    check("t7_pulses", pulses, 1);
    check("t7_num", got_num[0], -2);
    check("t7_idx", got_idx[0], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
